axi4_lite_slave: RTL and testbench
==================================

Name: axi4_lite_slave

Overview:
- AXI4-Lite responder for the bus master's read and write channels.
- Backs a NUM_REGS-word register file and accepts AW and W independently, in either order or together.
- Returns one write response per write and one read beat per read, with SLVERR for addresses outside the file.
- Sits opposite the master on the same bus; one outstanding transaction per direction.

Parameters:
- ADDR_WIDTH, 32, width of AWADDR/ARADDR.
- DATA_WIDTH, 32, width of WDATA/RDATA; must be 32 or 64.
- NUM_REGS, 16, number of DATA_WIDTH-bit registers; must be a power of two, at least 2.

Ports:
- ACLK  in  1  bus clock; all logic on the rising edge.
- ARESET  in  1  synchronous, active-high reset.
- AWADDR  in  ADDR_WIDTH  write address.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address accepted.
- WDATA  in  DATA_WIDTH  write data.
- WSTRB  in  DATA_WIDTH/8  byte strobes; present only with AXI_SLV_WSTRB_EN.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data accepted.
- BRESP  out  2  write response: 00 OKAY, 10 SLVERR.
- BVALID  out  1  write response valid.
- BREADY  in  1  master ready for response.
- ARADDR  in  ADDR_WIDTH  read address.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address accepted.
- RDATA  out  DATA_WIDTH  read data.
- RRESP  out  2  read response: 00 OKAY, 10 SLVERR.
- RVALID  out  1  read data valid.
- RREADY  in  1  master ready for data.

Behaviour:
- Reset: one clock, synchronous, active-high (ACLK, ARESET). While ARESET=1, every output is 0 (AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA), all registers clear to 0, and both holding flags clear.
- Reset mid-transaction: any captured address or data is discarded, no B or R beat is produced, and all outputs are 0 on the next cycle.
- Address decode:
  - BYTES = DATA_WIDTH/8.
  - Word index = addr[log2(BYTES) +: log2(NUM_REGS)].
  - Low log2(BYTES) address bits are ignored (unaligned accesses are treated as aligned).
  - An address is in range only if addr < NUM_REGS*BYTES; otherwise it is out of range.
- Write path:
  - Holding flags aw_held and w_held, each with a capture register.
  - AWREADY = !ARESET && !aw_held; WREADY = !ARESET && !w_held.
  - An AW handshake captures AWADDR and sets aw_held. A W handshake captures WDATA (and WSTRB when enabled) and sets w_held.
  - Commit cycle: aw_held && w_held && !BVALID. At its closing edge:
    - an in-range address is written and BRESP=00;
    - an out-of-range address writes nothing and BRESP=10;
    - BVALID is set and both held flags clear.
  - BVALID and BRESP stay stable until BVALID && BREADY, after which BVALID clears on that edge.
  - A new AW/W pair may be captured while BVALID is high; its commit waits until BVALID clears.
  - Latency: AW and W handshakes both at edge N give the commit edge at N+1 and BVALID high in cycle N+2 (BREADY=1, no prior response pending).
- Read path, two states:
  - R_IDLE: ARREADY=1 (when !ARESET). On the ARVALID handshake, RDATA is loaded from the register at that edge, RRESP=00 for in range, or RDATA=0 and RRESP=10 for out of range, RVALID=1, and the FSM moves to R_DATA.
  - R_DATA: ARREADY=0; RDATA, RRESP and RVALID are held stable. On RREADY, RVALID clears and the FSM returns to R_IDLE.
  - Read latency: RVALID is high in the cycle after the AR handshake.
  - No AR acceptance on the same edge as the R handshake; the next AR can be accepted one cycle later.
- Simultaneous events:
  - A read handshake and a write commit on the same edge to the same word: the read returns the pre-write value.
  - Read and write paths are fully independent otherwise.
- The slave never drops a handshake. The master may hold VALID indefinitely and the slave holds READY/VALID per the rules above.

Optional Feature:
- Macro AXI_SLV_WSTRB_EN.
- When defined: the WSTRB port exists and is captured with WDATA. On commit, only bytes with WSTRB[i]=1 update; other bytes keep their old values. WSTRB=0 still commits with BRESP=00 and leaves the register unchanged.
- When not defined: the WSTRB port is absent and every commit writes the full word.

Test Plan:
- Write addr 0x04 data 0xDEADBEEF with AW and W on the same cycle, BREADY=1 -> BVALID in cycle N+2, BRESP=00; then read 0x04 -> RDATA=0xDEADBEEF, RRESP=00, RVALID one cycle after the AR handshake.
- W at cycle 0 (data 0x11), AW at cycle 3 (addr 0x08) -> WREADY low cycles 1-3, AWREADY high until cycle 3, BVALID at cycle 5; read 0x08 = 0x11.
- Write 0x100 (NUM_REGS=16, 32-bit), then read 0x100 -> BRESP=10, RRESP=10, RDATA=0; all registers unchanged.
- BREADY held low for 5 cycles after BVALID, second AW/W presented -> second pair is captured, BVALID/BRESP stay stable, second BVALID appears only after the first B handshake, then AWREADY/WREADY reassert.
- With AXI_SLV_WSTRB_EN: reg 0x0C=0xFFFFFFFF, write 0x12345678 with WSTRB=0101 -> read 0x0C = 0xFF34FF78.
- ARESET asserted one cycle after an AW handshake with no W yet -> all outputs 0, no BVALID ever issued, a subsequent read of the target returns 0.

Source files
------------

// File: rtl/axi4_lite_slave.sv
// axi4_lite_slave: AXI4-Lite register-file responder; define AXI_SLV_WSTRB_EN to add WSTRB byte-lane writes
module axi4_lite_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
`ifdef AXI_SLV_WSTRB_EN
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
`endif
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF = $clog2(BYTES);
  localparam int IW = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(NUM_REGS * BYTES);
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic                  r_aw_held, r_w_held, r_bvalid;
  logic [ADDR_WIDTH-1:0] r_aw_addr;
  logic [DATA_WIDTH-1:0] r_w_data, r_rdata;
  logic [1:0]            r_bresp, r_rresp;
  r_state_t              r_rstate;
  logic [BYTES-1:0]      w_strb;
  logic [DATA_WIDTH-1:0] w_mask;
  logic                  w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_aw_ok, w_ar_ok;
`ifdef AXI_SLV_WSTRB_EN
  logic [BYTES-1:0]      r_w_strb;
  assign w_strb = r_w_strb;
`else
  assign w_strb = '1;
`endif
  assign w_aw_hs = AWVALID && AWREADY;
  assign w_w_hs = WVALID && WREADY;
  assign w_ar_hs = ARVALID && ARREADY;
  assign w_commit = r_aw_held && r_w_held && !r_bvalid;
  assign w_aw_ok = r_aw_addr < LIMIT;
  assign w_ar_ok = ARADDR < LIMIT;
  assign AWREADY = !ARESET && !r_aw_held;
  assign WREADY = !ARESET && !r_w_held;
  assign ARREADY = !ARESET && r_rstate == R_IDLE;
  assign BVALID = !ARESET && r_bvalid;
  assign BRESP = ARESET ? 2'b00 : r_bresp;
  assign RVALID = !ARESET && r_rstate == R_DATA;
  assign RRESP = ARESET ? 2'b00 : r_rresp;
  assign RDATA = ARESET ? '0 : r_rdata;
  // expand byte strobes into a bit mask for the read-modify-write commit
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < BYTES; i++) w_mask[i*8 +: 8] = {8{w_strb[i]}};
  end
  // write channel: independent AW/W capture, commit once both are held and no response is pending
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_aw_held <= 1'b0;
      r_w_held <= 1'b0;
      r_bvalid <= 1'b0;
      r_bresp <= 2'b00;
      r_aw_addr <= '0;
      r_w_data <= '0;
`ifdef AXI_SLV_WSTRB_EN
      r_w_strb <= '0;
`endif
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_aw_addr <= AWADDR;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_w_data <= WDATA;
`ifdef AXI_SLV_WSTRB_EN
        r_w_strb <= WSTRB;
`endif
      end
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held <= 1'b0;
        r_bvalid <= 1'b1;
        r_bresp <= w_aw_ok ? 2'b00 : 2'b10;
      end else if (r_bvalid && BREADY) begin
        r_bvalid <= 1'b0;
      end
    end
  end
  // register file: byte-masked update on an in-range commit
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_commit && w_aw_ok) begin
      r_regs[r_aw_addr[OFF +: IW]] <= (r_regs[r_aw_addr[OFF +: IW]] & ~w_mask) | (r_w_data & w_mask);
    end
  end
  // read channel: load the beat on the AR handshake, hold it until the master takes it
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_rstate <= R_IDLE;
      r_rdata <= '0;
      r_rresp <= 2'b00;
    end else if (w_ar_hs) begin
      r_rstate <= R_DATA;
      r_rdata <= w_ar_ok ? r_regs[ARADDR[OFF +: IW]] : '0;
      r_rresp <= w_ar_ok ? 2'b00 : 2'b10;
    end else if (r_rstate == R_DATA && RREADY) begin
      r_rstate <= R_IDLE;
    end
  end
endmodule

// File: tb/tb_axi4_lite_slave.sv
// tb_axi4_lite_slave: directed plus randomized checks of axi4_lite_slave against a word-array model
module tb_axi4_lite_slave;
  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [31:0] AWADDR = '0, WDATA = '0, ARADDR = '0;
  logic [3:0]  WSTRB = 4'hF;
  logic        AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0, ARVALID = 1'b0, RREADY = 1'b0;
  logic        AWREADY, WREADY, BVALID, ARREADY, RVALID;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] RDATA;
  logic [31:0] exp_regs [16];
  int          n_cmp = 0, n_err = 0;

  axi4_lite_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA),
`ifdef AXI_SLV_WSTRB_EN
    .WSTRB(WSTRB),
`endif
    .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  task automatic step;
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return a < 32'd64;
  endfunction

  function automatic int idx(input logic [31:0] a);
    return int'((a / 4) % 16);
  endfunction

  function automatic void m_clear;
    for (int i = 0; i < 16; i++) exp_regs[i] = '0;
  endfunction

  function automatic void m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [3:0] m;
    logic [31:0] v;
`ifdef AXI_SLV_WSTRB_EN
    m = s;
`else
    m = 4'hF;
`endif
    if (in_range(a)) begin
      v = exp_regs[idx(a)];
      for (int i = 0; i < 4; i++) if (m[i]) v[i*8 +: 8] = d[i*8 +: 8];
      exp_regs[idx(a)] = v;
    end
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int aw_dly = $urandom_range(0, 2);
    int w_dly = $urandom_range(0, 2);
    int t = 0;
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    logic [1:0] er = in_range(a) ? 2'b00 : 2'b10;
    AWADDR = a; WDATA = d; WSTRB = s; BREADY = 1'b0;
    while (!(aw_done && w_done) && t < 20) begin
      AWVALID = !aw_done && t >= aw_dly;
      WVALID = !w_done && t >= w_dly;
      aw_hs = AWVALID && AWREADY;
      w_hs = WVALID && WREADY;
      step;
      aw_done |= aw_hs;
      w_done |= w_hs;
      t++;
    end
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("aw_handshake", aw_done, 1);
    chk("w_handshake", w_done, 1);
    t = 0;
    while (!BVALID && t < 10) begin step; t++; end
    chk("bvalid_wait", BVALID, 1);
    chk("bresp", BRESP, er);
    repeat ($urandom_range(0, 2)) begin
      step;
      chk("b_hold", {BVALID, BRESP}, {1'b1, er});
    end
    BREADY = 1'b1;
    step;
    BREADY = 1'b0;
    chk("b_clear", BVALID, 0);
    m_write(a, d, s);
  endtask

  task automatic do_read(input logic [31:0] a);
    int t = 0;
    logic [31:0] ed = in_range(a) ? exp_regs[idx(a)] : 32'h0;
    logic [1:0] er = in_range(a) ? 2'b00 : 2'b10;
    ARADDR = a; ARVALID = 1'b1;
    while (!ARREADY && t < 10) begin step; t++; end
    chk("ar_ready", ARREADY, 1);
    step;
    ARVALID = 1'b0;
    chk("rvalid", RVALID, 1);
    chk("rdata", RDATA, ed);
    chk("rresp", RRESP, er);
    chk("ar_busy", ARREADY, 0);
    repeat ($urandom_range(0, 2)) begin
      step;
      chk("r_hold", {RVALID, RRESP, RDATA}, {1'b1, er, ed});
    end
    RREADY = 1'b1;
    step;
    RREADY = 1'b0;
    chk("r_clear", RVALID, 0);
    chk("ar_again", ARREADY, 1);
  endtask

  initial begin
    logic [31:0] a, d, old;
    m_clear();
    // reset state
    step; step;
    chk("rst_outs", {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA}, '0);
    ARESET = 1'b0;
    #1;
    chk("post_rst_ready", {AWREADY, WREADY, ARREADY}, 3'b111);
    // AW and W together: BVALID in N+2
    AWADDR = 32'h4; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
    step;
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("lat_n1_bvalid", BVALID, 0);
    step;
    chk("lat_n2_bvalid", BVALID, 1);
    chk("lat_n2_bresp", BRESP, 0);
    step;
    chk("lat_b_done", BVALID, 0);
    m_write(32'h4, 32'hDEADBEEF, 4'hF);
    do_read(32'h4);
    // W three cycles before AW
    WDATA = 32'h11; WVALID = 1'b1;
    step;
    WVALID = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk("wfirst_wready", WREADY, 0);
      chk("wfirst_awready", AWREADY, 1);
      if (c < 3) step;
    end
    AWADDR = 32'h8; AWVALID = 1'b1;
    step;
    AWVALID = 1'b0;
    chk("wfirst_c4_bvalid", BVALID, 0);
    step;
    chk("wfirst_c5_bvalid", BVALID, 1);
    step;
    m_write(32'h8, 32'h11, 4'hF);
    do_read(32'h8);
    // out of range
    do_write(32'h100, 32'hCAFEF00D, 4'hF);
    do_read(32'h100);
    for (int i = 0; i < 16; i++) do_read(32'(i * 4));
    // response back-pressure with a second pair captured behind it
    BREADY = 1'b0;
    AWADDR = 32'h10; WDATA = 32'hA1A1A1A1; AWVALID = 1'b1; WVALID = 1'b1;
    step;
    AWVALID = 1'b0; WVALID = 1'b0;
    step;
    chk("bp_first_bvalid", BVALID, 1);
    m_write(32'h10, 32'hA1A1A1A1, 4'hF);
    AWADDR = 32'h40; WDATA = 32'hB2B2B2B2; AWVALID = 1'b1; WVALID = 1'b1;
    chk("bp_aw_open", AWREADY, 1);
    step;
    AWVALID = 1'b0; WVALID = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("bp_b_stable", {BVALID, BRESP}, 3'b100);
      chk("bp_held", {AWREADY, WREADY}, 2'b00);
      step;
    end
    BREADY = 1'b1;
    step;
    chk("bp_gap_bvalid", BVALID, 0);
    step;
    chk("bp_second", {BVALID, BRESP}, 3'b110);
    chk("bp_reopen", {AWREADY, WREADY}, 2'b11);
    step;
    chk("bp_second_done", BVALID, 0);
    do_read(32'h10);
    // read and commit to the same word on one edge
    do_write(32'h20, 32'h0BADF00D, 4'hF);
    old = exp_regs[idx(32'h20)];
    BREADY = 1'b1;
    AWADDR = 32'h20; WDATA = 32'h600DCAFE; AWVALID = 1'b1; WVALID = 1'b1;
    step;
    AWVALID = 1'b0; WVALID = 1'b0;
    ARADDR = 32'h20; ARVALID = 1'b1;
    step;
    ARVALID = 1'b0;
    chk("coll_rdata", RDATA, old);
    chk("coll_bvalid", BVALID, 1);
    RREADY = 1'b1;
    step;
    RREADY = 1'b0; BREADY = 1'b0;
    m_write(32'h20, 32'h600DCAFE, 4'hF);
    do_read(32'h20);
`ifdef AXI_SLV_WSTRB_EN
    do_write(32'hC, 32'hFFFFFFFF, 4'hF);
    do_write(32'hC, 32'h12345678, 4'b0101);
    chk("strb_model", exp_regs[3], 32'hFF34FF78);
    do_read(32'hC);
    do_write(32'hC, 32'h0, 4'h0);
    do_read(32'hC);
`endif
    // reset after an AW handshake with no W
    BREADY = 1'b1;
    do_write(32'h18, 32'h5A5A5A5A, 4'hF);
    AWADDR = 32'h18; AWVALID = 1'b1;
    step;
    AWVALID = 1'b0;
    ARESET = 1'b1;
    #1;
    chk("mid_rst_outs", {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA}, '0);
    step;
    chk("mid_rst_outs2", {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA}, '0);
    ARESET = 1'b0;
    m_clear();
    #1;
    chk("mid_rst_aw_dropped", AWREADY, 1);
    for (int c = 0; c < 5; c++) begin
      chk("mid_rst_no_b", BVALID, 0);
      step;
    end
    BREADY = 1'b0;
    do_read(32'h18);
    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      a = $urandom_range(0, 79);
      d = $urandom;
      if ($urandom_range(0, 1) == 1) do_write(a, d, 4'($urandom_range(0, 15)));
      else do_read(a);
    end
    for (int i = 0; i < 16; i++) do_read(32'(i * 4));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
